// File: rtl/exe_alu_fwd.sv
// Execute-stage operand bypass, 32-bit ALU and HI/LO registers.
// Define ALU_FORWARD_EN to enable the two-level operand bypass muxes.
module exe_alu_fwd (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic [4:0]  RegA_IN,
  input  logic [31:0] OpA_IN,
  input  logic [4:0]  RegB_IN,
  input  logic [31:0] OpB_IN,
  input  logic [4:0]  Fwd1Reg,
  input  logic [31:0] Fwd1Data,
  input  logic        Fwd1Valid,
  input  logic [4:0]  Fwd2Reg,
  input  logic [31:0] Fwd2Data,
  input  logic        Fwd2Valid,
  input  logic [5:0]  ALU_Control,
  input  logic [4:0]  ShiftAmount,
  output logic [31:0] A_OUT,
  output logic [31:0] B_OUT,
  output logic [31:0] ALU_result,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_XOR   = 6'h04;
  localparam logic [5:0] OP_NOR   = 6'h05;
  localparam logic [5:0] OP_SLT   = 6'h06;
  localparam logic [5:0] OP_SLTU  = 6'h07;
  localparam logic [5:0] OP_SLL   = 6'h08;
  localparam logic [5:0] OP_SRL   = 6'h09;
  localparam logic [5:0] OP_SRA   = 6'h0A;
  localparam logic [5:0] OP_SLLV  = 6'h0B;
  localparam logic [5:0] OP_SRLV  = 6'h0C;
  localparam logic [5:0] OP_SRAV  = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0E;
  localparam logic [5:0] OP_MULT  = 6'h0F;
  localparam logic [5:0] OP_MULTU = 6'h10;
  localparam logic [5:0] OP_DIV   = 6'h11;
  localparam logic [5:0] OP_DIVU  = 6'h12;
  localparam logic [5:0] OP_MFHI  = 6'h13;
  localparam logic [5:0] OP_MFLO  = 6'h14;
  localparam logic [5:0] OP_MTHI  = 6'h15;
  localparam logic [5:0] OP_MTLO  = 6'h16;
  localparam logic [5:0] OP_PASSB = 6'h17;

  logic [31:0] a;
  logic [31:0] b;

`ifdef ALU_FORWARD_EN
  // Bypass muxes: EXE/MEM result beats MEM/WB result; $0 never bypassed
  always_comb begin
    a = OpA_IN;
    b = OpB_IN;
    if (Fwd1Valid && Fwd1Reg == RegA_IN && RegA_IN != 5'd0)
      a = Fwd1Data;
    else if (Fwd2Valid && Fwd2Reg == RegA_IN && RegA_IN != 5'd0)
      a = Fwd2Data;
    if (Fwd1Valid && Fwd1Reg == RegB_IN && RegB_IN != 5'd0)
      b = Fwd1Data;
    else if (Fwd2Valid && Fwd2Reg == RegB_IN && RegB_IN != 5'd0)
      b = Fwd2Data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{RegA_IN, RegB_IN, Fwd1Reg, Fwd1Data,
                        Fwd1Valid, Fwd2Reg, Fwd2Data, Fwd2Valid};
  assign a = OpA_IN;
  assign b = OpB_IN;
`endif

  assign A_OUT = a;
  assign B_OUT = b;

  logic [63:0] mul_s;
  logic [63:0] mul_u;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic        div_ovf;

  assign mul_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign mul_u = {32'd0, a} * {32'd0, b};
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Dividers; divide-by-zero and the overflow case never feed real results
  always_comb begin
    quo_s = 32'd0;
    rem_s = 32'd0;
    quo_u = 32'd0;
    rem_u = 32'd0;
    if (b != 32'd0) begin
      quo_u = a / b;
      rem_u = a % b;
      if (div_ovf) begin
        quo_s = 32'h8000_0000;
        rem_s = 32'd0;
      end else begin
        quo_s = $signed(a) / $signed(b);
        rem_s = $signed(a) % $signed(b);
      end
    end
  end

  // ALU result select; undefined and HI/LO-writing ops give zero
  always_comb begin
    ALU_result = 32'd0;
    case (ALU_Control)
      OP_ADD:   ALU_result = a + b;
      OP_SUB:   ALU_result = a - b;
      OP_AND:   ALU_result = a & b;
      OP_OR:    ALU_result = a | b;
      OP_XOR:   ALU_result = a ^ b;
      OP_NOR:   ALU_result = ~(a | b);
      OP_SLT:   ALU_result = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU:  ALU_result = {31'd0, a < b};
      OP_SLL:   ALU_result = b << ShiftAmount;
      OP_SRL:   ALU_result = b >> ShiftAmount;
      OP_SRA:   ALU_result = $signed(b) >>> ShiftAmount;
      OP_SLLV:  ALU_result = b << a[4:0];
      OP_SRLV:  ALU_result = b >> a[4:0];
      OP_SRAV:  ALU_result = $signed(b) >>> a[4:0];
      OP_LUI:   ALU_result = b << 16;
      OP_MFHI:  ALU_result = HI;
      OP_MFLO:  ALU_result = LO;
      OP_PASSB: ALU_result = b;
      default:  ALU_result = 32'd0;
    endcase
  end

  // HI/LO update; held on stall, divide-by-zero and non-writing ops
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (!STALL) begin
      case (ALU_Control)
        OP_MULT: begin
          HI <= mul_s[63:32];
          LO <= mul_s[31:0];
        end
        OP_MULTU: begin
          HI <= mul_u[63:32];
          LO <= mul_u[31:0];
        end
        OP_DIV: if (b != 32'd0) begin
          HI <= rem_s;
          LO <= quo_s;
        end
        OP_DIVU: if (b != 32'd0) begin
          HI <= rem_u;
          LO <= quo_u;
        end
        OP_MTHI: HI <= a;
        OP_MTLO: LO <= a;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_alu_fwd.sv
// Directed-vector bench for exe_alu_fwd.
// Expected values hand-computed; bypass expectations follow ALU_FORWARD_EN.
module tb_exe_alu_fwd;

  logic        CLK;
  logic        RESET;
  logic        STALL;
  logic [4:0]  RegA_IN;
  logic [31:0] OpA_IN;
  logic [4:0]  RegB_IN;
  logic [31:0] OpB_IN;
  logic [4:0]  Fwd1Reg;
  logic [31:0] Fwd1Data;
  logic        Fwd1Valid;
  logic [4:0]  Fwd2Reg;
  logic [31:0] Fwd2Data;
  logic        Fwd2Valid;
  logic [5:0]  ALU_Control;
  logic [4:0]  ShiftAmount;
  logic [31:0] A_OUT;
  logic [31:0] B_OUT;
  logic [31:0] ALU_result;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_cmp = 0;
  int n_bad = 0;

  exe_alu_fwd dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL),
    .RegA_IN(RegA_IN), .OpA_IN(OpA_IN),
    .RegB_IN(RegB_IN), .OpB_IN(OpB_IN),
    .Fwd1Reg(Fwd1Reg), .Fwd1Data(Fwd1Data), .Fwd1Valid(Fwd1Valid),
    .Fwd2Reg(Fwd2Reg), .Fwd2Data(Fwd2Data), .Fwd2Valid(Fwd2Valid),
    .ALU_Control(ALU_Control), .ShiftAmount(ShiftAmount),
    .A_OUT(A_OUT), .B_OUT(B_OUT), .ALU_result(ALU_result),
    .HI(HI), .LO(LO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle();
    STALL = 1'b0;
    RegA_IN = 5'd0; OpA_IN = 32'd0;
    RegB_IN = 5'd0; OpB_IN = 32'd0;
    Fwd1Reg = 5'd0; Fwd1Data = 32'd0; Fwd1Valid = 1'b0;
    Fwd2Reg = 5'd0; Fwd2Data = 32'd0; Fwd2Valid = 1'b0;
    ALU_Control = 6'h00; ShiftAmount = 5'd0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (HI !== 32'd0 || LO !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_hilo: HI=%h LO=%h want 0/0", HI, LO);
    end
    OpA_IN = 32'd3; OpB_IN = 32'd4; #1;
    n_cmp++;
    if (ALU_result !== 32'd7) begin
      n_bad++;
      $display("FAIL reset_comb: got %h want 7", ALU_result);
    end
    @(negedge CLK);
    RESET = 1'b1;
    idle();
  endtask

  task automatic test_forward();
    logic [31:0] exp;
    @(negedge CLK);
    RegA_IN = 5'd5; OpA_IN = 32'd1; OpB_IN = 32'd0;
    Fwd1Reg = 5'd5; Fwd1Data = 32'hAA; Fwd1Valid = 1'b1;
    Fwd2Reg = 5'd5; Fwd2Data = 32'hBB; Fwd2Valid = 1'b1;
`ifdef ALU_FORWARD_EN
    exp = 32'hAA;
`else
    exp = 32'h1;
`endif
    #1;
    n_cmp++;
    if (ALU_result !== exp || A_OUT !== exp) begin
      n_bad++;
      $display("FAIL fwd1: res=%h A=%h want %h", ALU_result, A_OUT, exp);
    end
    Fwd1Valid = 1'b0;
`ifdef ALU_FORWARD_EN
    exp = 32'hBB;
`else
    exp = 32'h1;
`endif
    #1;
    n_cmp++;
    if (ALU_result !== exp) begin
      n_bad++;
      $display("FAIL fwd2: got %h want %h", ALU_result, exp);
    end
    RegA_IN = 5'd3; RegB_IN = 5'd7; OpB_IN = 32'h99;
    Fwd1Reg = 5'd7; Fwd1Data = 32'h10; Fwd1Valid = 1'b1;
    Fwd2Reg = 5'd7; Fwd2Data = 32'h20; Fwd2Valid = 1'b1;
    ALU_Control = 6'h17;
`ifdef ALU_FORWARD_EN
    exp = 32'h10;
`else
    exp = 32'h99;
`endif
    #1;
    n_cmp++;
    if (B_OUT !== exp || ALU_result !== exp || A_OUT !== 32'd1) begin
      n_bad++;
      $display("FAIL fwd_b: B=%h res=%h A=%h want %h/1",
               B_OUT, ALU_result, A_OUT, exp);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    @(negedge CLK);
    RegA_IN = 5'd0; OpA_IN = 32'd7; OpB_IN = 32'd3;
    Fwd1Reg = 5'd0; Fwd1Data = 32'hFFFF; Fwd1Valid = 1'b1;
    Fwd2Reg = 5'd0; Fwd2Data = 32'hEEEE; Fwd2Valid = 1'b1;
    ALU_Control = 6'h01;
    #1;
    n_cmp++;
    if (ALU_result !== 32'd4) begin
      n_bad++;
      $display("FAIL zero_reg: got %h want 4", ALU_result);
    end
    idle();
  endtask

  task automatic test_logic_ops();
    logic [5:0]  ops [8] = '{6'h00, 6'h01, 6'h02, 6'h03,
                             6'h04, 6'h05, 6'h06, 6'h07};
    logic [31:0] av [8] = '{32'hFFFF_FFFF, 32'd3, 32'hF0F0_00FF,
                            32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bv [8] = '{32'd2, 32'd5, 32'h0FF0_0F0F, 32'h0FF0_0F0F,
                            32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'd1, 32'd1};
    logic [31:0] ev [8] = '{32'd1, 32'hFFFF_FFFE, 32'h00F0_000F,
                            32'hFFF0_0FFF, 32'hFF00_0FF0, 32'h000F_F000,
                            32'd1, 32'd0};
    for (int i = 0; i < 8; i++) begin
      ALU_Control = ops[i]; OpA_IN = av[i]; OpB_IN = bv[i];
      #1;
      n_cmp++;
      if (ALU_result !== ev[i]) begin
        n_bad++;
        $display("FAIL alu_op%0h: got %h want %h", ops[i], ALU_result, ev[i]);
      end
    end
    idle();
  endtask

  task automatic test_shifts();
    logic [5:0]  ops [8] = '{6'h08, 6'h09, 6'h0A, 6'h0B,
                             6'h0C, 6'h0D, 6'h0E, 6'h17};
    logic [31:0] av [8] = '{32'd0, 32'd0, 32'd0, 32'h24,
                            32'h3F, 32'h21, 32'd0, 32'd0};
    logic [31:0] bv [8] = '{32'd1, 32'h8000_0000, 32'h8000_0000, 32'd3,
                            32'h8000_0000, 32'h8000_0000, 32'h1234,
                            32'hDEAD};
    logic [4:0]  sv [8] = '{5'd31, 5'd4, 5'd4, 5'd0,
                            5'd0, 5'd0, 5'd0, 5'd0};
    logic [31:0] ev [8] = '{32'h8000_0000, 32'h0800_0000, 32'hF800_0000,
                            32'h30, 32'h1, 32'hC000_0000, 32'h1234_0000,
                            32'hDEAD};
    for (int i = 0; i < 8; i++) begin
      ALU_Control = ops[i]; OpA_IN = av[i]; OpB_IN = bv[i];
      ShiftAmount = sv[i];
      #1;
      n_cmp++;
      if (ALU_result !== ev[i]) begin
        n_bad++;
        $display("FAIL shift_op%0h: got %h want %h", ops[i], ALU_result, ev[i]);
      end
    end
    ALU_Control = 6'h3F; OpA_IN = 32'd5; OpB_IN = 32'd6;
    #1;
    n_cmp++;
    if (ALU_result !== 32'd0) begin
      n_bad++;
      $display("FAIL undef_op: got %h want 0", ALU_result);
    end
    idle();
  endtask

  task automatic hl_op(input logic [5:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic stall);
    @(negedge CLK);
    ALU_Control = op; OpA_IN = av; OpB_IN = bv; STALL = stall;
    #1;
    n_cmp++;
    if (ALU_result !== 32'd0) begin
      n_bad++;
      $display("FAIL hl_res_op%0h: got %h want 0", op, ALU_result);
    end
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic chk_hl(input string nm, input logic [31:0] eh,
                        input logic [31:0] el);
    n_cmp++;
    if (HI !== eh || LO !== el) begin
      n_bad++;
      $display("FAIL %s: HI=%h LO=%h want %h/%h", nm, HI, LO, eh, el);
    end
  endtask

  task automatic test_mult();
    hl_op(6'h0F, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    hl_op(6'h10, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk_hl("multu", 32'd1, 32'hFFFF_FFFE);
  endtask

  task automatic test_div();
    hl_op(6'h11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    hl_op(6'h11, 32'd9, 32'd0, 1'b0);
    chk_hl("div_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    hl_op(6'h12, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk_hl("divu", 32'd1, 32'h7FFF_FFFC);
    hl_op(6'h11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk_hl("div_ovf", 32'd0, 32'h8000_0000);
    hl_op(6'h3F, 32'd1, 32'd1, 1'b0);
    chk_hl("undef_hold", 32'd0, 32'h8000_0000);
  endtask

  task automatic test_move_stall();
    hl_op(6'h15, 32'h1234, 32'd0, 1'b1);
    chk_hl("mthi_stall", 32'd0, 32'h8000_0000);
    @(negedge CLK);
    ALU_Control = 6'h15; OpA_IN = 32'h1234;
    #1;
    n_cmp++;
    if (ALU_result !== 32'd0) begin
      n_bad++;
      $display("FAIL mthi_same_cycle: got %h want 0", ALU_result);
    end
    @(posedge CLK);
    #1;
    ALU_Control = 6'h13;
    #1;
    n_cmp++;
    if (ALU_result !== 32'h1234) begin
      n_bad++;
      $display("FAIL mfhi: got %h want 1234", ALU_result);
    end
    idle();
    hl_op(6'h16, 32'h5678, 32'd0, 1'b0);
    ALU_Control = 6'h14;
    #1;
    n_cmp++;
    if (ALU_result !== 32'h5678 || HI !== 32'h1234) begin
      n_bad++;
      $display("FAIL mflo: got %h HI=%h want 5678/1234", ALU_result, HI);
    end
    idle();
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    chk_hl("async_reset", 32'd0, 32'd0);
    ALU_Control = 6'h15; OpA_IN = 32'hABCD;
    @(posedge CLK);
    #1;
    chk_hl("reset_hold", 32'd0, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    idle();
    hl_op(6'h15, 32'hABCD, 32'd0, 1'b0);
    chk_hl("post_reset", 32'hABCD, 32'd0);
  endtask

  initial begin
    idle();
    RESET = 1'b0;
    test_reset();
    test_forward();
    test_zero_reg();
    test_logic_ops();
    test_shifts();
    test_mult();
    test_div();
    test_move_stall();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
